// File: rtl/uart_rx_if.sv
// Serial-receive bus: tick and line in, captured frame and status flags out.
interface uart_rx_if;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  // Driver side: supplies the oversampling tick and the serial line.
  modport master (
    output s_tick,
    output rx,
    input  dout,
    input  rx_done_tick,
    input  frame_err,
    input  parity_err
  );

  // Receiver side.
  modport slave (
    input  s_tick,
    input  rx,
    output dout,
    output rx_done_tick,
    output frame_err,
    output parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, optional parity and configurable stop length.
module uart_rx #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] rx_sync_q, rx_sync_d;
  logic [5:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic       par_q, par_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic       perr_q, perr_d;

  logic       rx_s;
  logic [7:0] data_aligned;
  logic       parity_calc;

  assign rx_s         = rx_sync_q[1];
  // Data bits arrive LSB first and end up in the top DBIT bits of b.
  assign data_aligned = b_q >> (8 - DBIT);
  assign parity_calc  = (^data_aligned) ^ par_q ^ 1'(PARITY_ODD);

  // State, counters, synchronizer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rx_sync_q <= 2'b11;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      par_q     <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_sync_q <= rx_sync_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      par_q     <= par_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state logic; all bit-timing moves only on s_tick.
  always_comb begin
    state_d   = state_q;
    rx_sync_d = {rx_sync_q[0], bus.rx};
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    par_d     = par_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    ferr_d    = ferr_q;
    perr_d    = perr_q;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (bus.s_tick) begin
          if (s_q == 6'd7) begin
            // A line that has gone high again by mid-start-bit was a glitch.
            if (!rx_s) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      StData: begin
        if (bus.s_tick) begin
          if (s_q == 6'd15) begin
            b_d = {rx_s, b_q[7:1]};
            s_d = '0;
            if (n_q == 3'(DBIT - 1)) begin
              state_d = (PARITY_EN != 0) ? StParity : StStop;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      StParity: begin
        if (bus.s_tick) begin
          if (s_q == 6'd15) begin
            par_d   = rx_s;
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      StStop: begin
        if (bus.s_tick) begin
          if (s_q == 6'(SB_TICK - 1)) begin
            dout_d  = data_aligned;
            ferr_d  = ~rx_s;
            perr_d  = (PARITY_EN != 0) ? parity_calc : 1'b0;
            done_d  = 1'b1;
            s_d     = '0;
            // A low stop bit means a break; hold off until the line recovers.
            state_d = rx_s ? StIdle : StWaitHigh;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.parity_err   = perr_q;

endmodule
